// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one burst-oriented backing-memory channel between the instruction
// cache (port 0) and the data cache (port 1).
//   - Round-robin grant in IDLE; a line read occupies the channel for a single
//     accepted cycle, so the next grant can happen on the following cycle.
//   - A write burst of NUM_BEATS beats is locked to its owner until the last
//     beat has been accepted.
//   - Each port may have one outstanding line read. Response beats are matched
//     on line address and steered to every port waiting on that line; a beat
//     that matches nothing is dropped and flagged on resp_err.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   p0_* / p1_*              requester side: addr, read, write, wdata in;
//                            ready, raddr, rdata, rvalid out
//   mem_addr/read/write/wdata  forwarded request to memory
//   mem_ready                memory accepts the forwarded request
//   mem_raddr/rdata/rvalid   memory read response
//   resp_err                 one-cycle pulse: response beat matched no port
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int NUM_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ready,
  output logic [ADDR_W-1:0] p0_raddr,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_rvalid,

  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ready,
  output logic [ADDR_W-1:0] p1_raddr,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_rvalid,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,

  output logic              resp_err
);

  localparam int BW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [BW-1:0]     LAST_BEAT = BW'(NUM_BEATS - 1);
  // Line address: the low 5 address bits select a byte within the line.
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(32'h1F);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WR_BURST = 1'b1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [0:0]        state;
  logic              owner;      // port holding the write burst
  logic              prio;       // port that wins a tie in IDLE
  logic [BW-1:0]     wbeat;      // beats already accepted in the burst
  logic [1:0]        pend_rd;    // outstanding line read per port
  logic [ADDR_W-1:0] pend_addr [2];
  logic [BW-1:0]     rbeat     [2];

  // ---------------------------------------------------------------------------
  // Request side (combinational, zero-cycle)
  // ---------------------------------------------------------------------------
  logic [1:0]        req_rd;
  logic [1:0]        req_wr;
  logic [ADDR_W-1:0] req_addr [2];
  logic [1:0]        elig;
  logic              gnt_valid;
  logic              gnt;
  logic              gnt_rd;
  logic              gnt_wr;
  logic              fire;

  assign req_rd      = {p1_read, p0_read};
  assign req_wr      = {p1_write, p0_write};
  assign req_addr[0] = p0_addr;
  assign req_addr[1] = p1_addr;

  // A port whose line read is still outstanding may not issue another read,
  // but it may still write.
  assign elig = req_wr | (req_rd & ~pend_rd);

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = 1'b0;
    if (state == WR_BURST) begin
      gnt_valid = 1'b1;
      gnt       = owner;
    end else if (elig == 2'b11) begin
      gnt_valid = 1'b1;
      gnt       = prio;
    end else if (elig[1]) begin
      gnt_valid = 1'b1;
      gnt       = 1'b1;
    end else if (elig[0]) begin
      gnt_valid = 1'b1;
      gnt       = 1'b0;
    end
  end

  assign gnt_rd = req_rd[gnt];
  assign gnt_wr = req_wr[gnt];

  // Strobes are gated with rst so they drop the instant reset asserts, even
  // though the requesters may still be driving their request lines.
  // Write wins over read on the granted port; reads are never forwarded while
  // a burst owns the channel.
  assign mem_write = rst & gnt_valid & gnt_wr;
  assign mem_read  = rst & gnt_valid & (state == IDLE) & gnt_rd & ~gnt_wr;
  assign mem_addr  = req_addr[gnt];
  assign mem_wdata = gnt ? p1_wdata : p0_wdata;

  assign p0_ready  = rst & gnt_valid & ~gnt & mem_ready;
  assign p1_ready  = rst & gnt_valid &  gnt & mem_ready;

  assign fire      = (mem_read | mem_write) & mem_ready;

  // ---------------------------------------------------------------------------
  // Response side (combinational steering)
  // ---------------------------------------------------------------------------
  logic [1:0] match;

  assign match[0] = mem_rvalid & pend_rd[0] & (mem_raddr == pend_addr[0]);
  assign match[1] = mem_rvalid & pend_rd[1] & (mem_raddr == pend_addr[1]);

  assign p0_raddr  = mem_raddr;
  assign p1_raddr  = mem_raddr;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;
  assign p0_rvalid = rst & match[0];
  assign p1_rvalid = rst & match[1];
  assign resp_err  = rst & mem_rvalid & ~(|match);

  // ---------------------------------------------------------------------------
  // Sequential update
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only, so every read
  // of state in this block sees the value from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      prio    <= 1'b0;
      wbeat   <= '0;
      pend_rd <= '0;
      // NOTE: the per-port address/beat arrays are only two entries of flops,
      // not a RAM, so they are reset alongside the rest of the state.
      for (int p = 0; p < 2; p++) begin
        pend_addr[p] <= '0;
        rbeat[p]     <= '0;
      end
    end else begin
      // Request acceptance. A read fire needs ~pend_rd[gnt] and a response
      // clear needs pend_rd[p], so the two never touch the same port at once.
      if (fire) begin
        if (state == IDLE) begin
          if (mem_write) begin
            state <= WR_BURST;
            owner <= gnt;
            wbeat <= BW'(1);
          end else begin
            pend_rd[gnt]   <= 1'b1;
            pend_addr[gnt] <= req_addr[gnt] & LINE_MASK;
            rbeat[gnt]     <= '0;
            prio           <= ~gnt;
          end
        end else begin
          if (wbeat == LAST_BEAT) begin
            state <= IDLE;
            prio  <= ~owner;
            wbeat <= '0;
          end else begin
            wbeat <= wbeat + 1'b1;
          end
        end
      end

      // Response beats are counted in any state, including mid-burst.
      for (int p = 0; p < 2; p++) begin
        if (match[p]) begin
          rbeat[p] <= rbeat[p] + 1'b1;
          if (rbeat[p] == LAST_BEAT) pend_rd[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Inputs change 1 time unit after a rising
// edge; combinational outputs are sampled 1 unit later, registered state right
// after the following edge. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] p0_addr,  p1_addr;
  logic        p0_read,  p1_read;
  logic        p0_write, p1_write;
  logic [63:0] p0_wdata, p1_wdata;
  logic        p0_ready, p1_ready;
  logic [31:0] p0_raddr, p1_raddr;
  logic [63:0] p0_rdata, p1_rdata;
  logic        p0_rvalid, p1_rvalid;
  logic [31:0] mem_addr;
  logic        mem_read, mem_write;
  logic [63:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
  logic        resp_err;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_addr(p0_addr), .p0_read(p0_read), .p0_write(p0_write), .p0_wdata(p0_wdata),
    .p0_ready(p0_ready), .p0_raddr(p0_raddr), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
    .p1_addr(p1_addr), .p1_read(p1_read), .p1_write(p1_write), .p1_wdata(p1_wdata),
    .p1_ready(p1_ready), .p1_raddr(p1_raddr), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Interleaved responses for the two-port routing step: line, p0, p1, err.
  logic [31:0] rsp_addr [9] = '{32'h4000, 32'h5000, 32'h5000, 32'h6000, 32'h4000,
                                32'h4000, 32'h5000, 32'h4000, 32'h5000};
  logic        rsp_p0   [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic        rsp_p1   [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        rsp_err  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    rst = 1'b0;
    p0_addr = '0; p0_read = 1'b0; p0_write = 1'b0; p0_wdata = '0;
    p1_addr = '0; p1_read = 1'b0; p1_write = 1'b0; p1_wdata = '0;
    mem_ready = 1'b1; mem_raddr = '0; mem_rdata = '0; mem_rvalid = 1'b0;

    // ---- Reset: strobes forced low even with a live request ----------------
    p0_read = 1'b1; p0_addr = 32'h1000;
    mem_rvalid = 1'b1; mem_raddr = 32'h1000;
    #1;
    check("rst_mem_read",  64'(mem_read),  64'd0);
    check("rst_p0_ready",  64'(p0_ready),  64'd0);
    check("rst_p0_rvalid", 64'(p0_rvalid), 64'd0);
    check("rst_resp_err",  64'(resp_err),  64'd0);
    check("rst_state",     64'(dut.state), 64'd0);
    check("rst_prio",      64'(dut.prio),  64'd0);
    check("rst_pend_rd",   64'(dut.pend_rd), 64'd0);
    p0_read = 1'b0; mem_rvalid = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // ---- Port 0 line read, 4 beats, re-request blocked while pending -------
    p0_addr = 32'h1004; p0_read = 1'b1;
    #1;
    check("rd_p0_ready",  64'(p0_ready),  64'd1);
    check("rd_mem_read",  64'(mem_read),  64'd1);
    check("rd_mem_write", 64'(mem_write), 64'd0);
    check("rd_mem_addr",  64'(mem_addr),  64'h1004);
    check("rd_p1_ready",  64'(p1_ready),  64'd0);
    tick();
    check("rd_pend_rd",   64'(dut.pend_rd), 64'b01);
    check("rd_pend_addr", 64'(dut.pend_addr[0]), 64'h1000);
    check("rd_prio",      64'(dut.prio), 64'd1);
    p0_addr = 32'h1000;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_raddr = 32'h1000; mem_rdata = 64'hA0 + 64'(i);
      #1;
      check("rd_p0_rvalid", 64'(p0_rvalid), 64'd1);
      check("rd_p1_rvalid", 64'(p1_rvalid), 64'd0);
      check("rd_p0_rdata",  p0_rdata, 64'hA0 + 64'(i));
      check("rd_p0_raddr",  64'(p0_raddr), 64'h1000);
      check("rd_resp_err",  64'(resp_err), 64'd0);
      check("pend_p0_ready", 64'(p0_ready), 64'd0);
      check("pend_mem_read", 64'(mem_read), 64'd0);
      tick();
    end
    mem_rvalid = 1'b0; mem_ready = 1'b0;
    #1;
    check("rd_pend_clear",   64'(dut.pend_rd), 64'd0);
    check("pend_after_read", 64'(mem_read), 64'd1);
    check("pend_after_addr", 64'(mem_addr), 64'h1000);
    p0_read = 1'b0; mem_ready = 1'b1;
    tick();

    // ---- Read vs write after reset, then locked burst ---------------------
    do_reset();
    p0_read = 1'b1; p0_addr = 32'h2000;
    p1_write = 1'b1; p1_addr = 32'h3000; p1_wdata = 64'h1111_0000;
    #1;
    check("tie_p0_ready",  64'(p0_ready),  64'd1);
    check("tie_p1_ready",  64'(p1_ready),  64'd0);
    check("tie_mem_read",  64'(mem_read),  64'd1);
    check("tie_mem_write", 64'(mem_write), 64'd0);
    check("tie_mem_addr",  64'(mem_addr),  64'h2000);
    tick();
    p0_read = 1'b0;
    #1;
    check("wr1_p1_ready",  64'(p1_ready),  64'd1);
    check("wr1_p0_ready",  64'(p0_ready),  64'd0);
    check("wr1_mem_write", 64'(mem_write), 64'd1);
    check("wr1_mem_addr",  64'(mem_addr),  64'h3000);
    check("wr1_mem_wdata", mem_wdata, 64'h1111_0000);
    tick();
    check("wr1_state", 64'(dut.state), 64'd1);
    check("wr1_wbeat", 64'(dut.wbeat), 64'd1);
    // p0 asks to write mid-burst and receives 3 of its 4 read beats.
    p0_write = 1'b1; p0_addr = 32'h2800;
    for (int b = 1; b < 4; b++) begin
      p1_wdata = 64'h1111_0000 + 64'(b);
      mem_rvalid = 1'b1; mem_raddr = 32'h2000;
      #1;
      check("brst_p0_ready",  64'(p0_ready),  64'd0);
      check("brst_p1_ready",  64'(p1_ready),  64'd1);
      check("brst_mem_write", 64'(mem_write), 64'd1);
      check("brst_mem_read",  64'(mem_read),  64'd0);
      check("brst_mem_addr",  64'(mem_addr),  64'h3000);
      check("brst_mem_wdata", mem_wdata, 64'h1111_0000 + 64'(b));
      check("brst_p0_rvalid", 64'(p0_rvalid), 64'd1);
      tick();
    end
    check("brst_end_state", 64'(dut.state), 64'd0);
    check("brst_end_prio",  64'(dut.prio),  64'd0);
    p1_write = 1'b0; mem_ready = 1'b0;
    #1;
    check("post_mem_write", 64'(mem_write), 64'd1);
    check("post_mem_addr",  64'(mem_addr),  64'h2800);
    check("post_p0_ready",  64'(p0_ready),  64'd0);
    check("post_p0_rvalid", 64'(p0_rvalid), 64'd1);
    tick();
    check("post_pend_rd", 64'(dut.pend_rd), 64'd0);
    p0_write = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b1;
    tick();

    // ---- Port 1 burst stalled by mem_ready on beat 2 -----------------------
    p1_write = 1'b1; p1_addr = 32'h7000; p1_wdata = 64'h7777_0000;
    #1;
    check("stl_b1_ready", 64'(p1_ready), 64'd1);
    tick();
    check("stl_b1_wbeat", 64'(dut.wbeat), 64'd1);
    check("stl_b1_owner", 64'(dut.owner), 64'd1);
    mem_ready = 1'b0;
    repeat (3) begin
      #1;
      check("stl_p1_ready",  64'(p1_ready),  64'd0);
      check("stl_mem_write", 64'(mem_write), 64'd1);
      tick();
      check("stl_wbeat", 64'(dut.wbeat), 64'd1);
      check("stl_owner", 64'(dut.owner), 64'd1);
      check("stl_state", 64'(dut.state), 64'd1);
    end
    mem_ready = 1'b1;
    for (int b = 2; b <= 4; b++) begin
      #1;
      check("stl_go_ready", 64'(p1_ready), 64'd1);
      tick();
      if (b < 4) check("stl_go_wbeat", 64'(dut.wbeat), 64'(b));
    end
    check("stl_done_state", 64'(dut.state), 64'd0);
    check("stl_done_prio",  64'(dut.prio),  64'd0);
    p1_write = 1'b0;
    tick();

    // ---- Both ports pending, interleaved responses, stray beat -------------
    p0_read = 1'b1; p0_addr = 32'h4000;
    p1_read = 1'b1; p1_addr = 32'h5000;
    #1;
    check("two_p0_ready", 64'(p0_ready), 64'd1);
    check("two_p1_ready", 64'(p1_ready), 64'd0);
    check("two_addr0",    64'(mem_addr), 64'h4000);
    tick();
    #1;
    check("two_p1_ready2", 64'(p1_ready), 64'd1);
    check("two_p0_ready2", 64'(p0_ready), 64'd0);
    check("two_addr1",     64'(mem_addr), 64'h5000);
    tick();
    p0_read = 1'b0; p1_read = 1'b0;
    for (int i = 0; i < 9; i++) begin
      mem_rvalid = 1'b1; mem_raddr = rsp_addr[i];
      #1;
      check("rt_p0_rvalid", 64'(p0_rvalid), 64'(rsp_p0[i]));
      check("rt_p1_rvalid", 64'(p1_rvalid), 64'(rsp_p1[i]));
      check("rt_resp_err",  64'(resp_err),  64'(rsp_err[i]));
      tick();
    end
    mem_rvalid = 1'b0; mem_raddr = 32'h6000;
    #1;
    check("rt_no_valid_err", 64'(resp_err), 64'd0);
    check("rt_pend_clear",   64'(dut.pend_rd), 64'd0);

    // ---- Both ports pending on the same line --------------------------------
    p0_read = 1'b1; p1_read = 1'b1; p0_addr = 32'h8000; p1_addr = 32'h8010;
    #1;
    check("same_p0_ready", 64'(p0_ready), 64'd1);
    tick();
    #1;
    check("same_p1_ready", 64'(p1_ready), 64'd1);
    tick();
    p0_read = 1'b0; p1_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1; mem_raddr = 32'h8000;
      #1;
      check("same_p0_rvalid", 64'(p0_rvalid), 64'd1);
      check("same_p1_rvalid", 64'(p1_rvalid), 64'd1);
      check("same_resp_err",  64'(resp_err),  64'd0);
      tick();
    end
    mem_rvalid = 1'b0;
    #1;
    check("same_pend_clear", 64'(dut.pend_rd), 64'd0);
    tick();

    // ---- Reset in the middle of a write burst -------------------------------
    p1_write = 1'b1; p1_addr = 32'h9000; p1_wdata = 64'h9999;
    tick();
    tick();
    check("mid_wbeat", 64'(dut.wbeat), 64'd2);
    rst = 1'b0;
    #1;
    check("mid_rst_mem_write", 64'(mem_write), 64'd0);
    check("mid_rst_p1_ready",  64'(p1_ready),  64'd0);
    check("mid_rst_state",     64'(dut.state), 64'd0);
    check("mid_rst_wbeat",     64'(dut.wbeat), 64'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rel_state",     64'(dut.state), 64'd0);
    check("rel_prio",      64'(dut.prio),  64'd0);
    check("rel_p1_ready",  64'(p1_ready),  64'd1);
    check("rel_mem_write", 64'(mem_write), 64'd1);
    tick();
    check("rel_wbeat", 64'(dut.wbeat), 64'd1);
    check("rel_burst", 64'(dut.state), 64'd1);
    p1_write = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
